// File: rtl/alu_pkg.sv
// Constants shared by the ALU datapath stages (half adder, full adder, 3-bit adder).
package alu_pkg;
    localparam int ALU_SYNC_STAGES_DEFAULT = 2;
    localparam int ALU_OPERAND_WIDTH       = 3;
endpackage

// File: rtl/dff_sync.sv
// Single-bit multi-flop synchronizer; only the first flop may see the asynchronous input.
module dff_sync
    import alu_pkg::*;
#(
    parameter int SYNC_STAGES = ALU_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_sync,
    output logic sync_out
);
    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[SYNC_STAGES-2:0], in_sync};
    end

    assign sync_out = chain[SYNC_STAGES-1];
endmodule

// File: rtl/half_adder_sync.sv
// Clocked half adder: per-bit synchronizers, registered sum/carry and a
// saturating counter that flags when the pipeline holds only post-reset samples.
module half_adder_sync
    import alu_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = ALU_SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] c_out,
    output logic             out_valid
);
    localparam int CNT_MAX = SYNC_STAGES + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [WIDTH-1:0]   a_s;
    logic [WIDTH-1:0]   b_s;
    logic [2*WIDTH-1:0] ha;
    logic [CNT_W-1:0]   cnt;

    // Lanes are independent: result is {carry, sum} with no inter-lane carry.
    function automatic logic [2*WIDTH-1:0] half_adder_core(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        return {a & b, a ^ b};
    endfunction

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        dff_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_sync (in_a[i]),
            .sync_out(a_s[i])
        );
        dff_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_sync (in_b[i]),
            .sync_out(b_s[i])
        );
    end

    assign ha = half_adder_core(a_s, b_s);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_out <= '0;
            c_out <= '0;
        end else begin
            s_out <= ha[WIDTH-1:0];
            c_out <= ha[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                   cnt <= '0;
        else if (cnt != CNT_W'(CNT_MAX)) cnt <= cnt + 1'b1;
    end

    assign out_valid = (cnt == CNT_W'(CNT_MAX));
endmodule

// File: tb/tb_half_adder_sync.sv
// Directed bench: default instance (WIDTH=1, 2 stages) plus a 3-lane, 3-stage instance.
module tb_half_adder_sync;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] a1, b1, s1, c1;
    logic       v1;
    logic [2:0] a3, b3, s3, c3;
    logic       v3;
    int         vectors = 0;
    int         errors  = 0;

    always #5 clk = ~clk;

    half_adder_sync dut1 (
        .clk(clk), .rst_n(rst_n), .in_a(a1), .in_b(b1),
        .s_out(s1), .c_out(c1), .out_valid(v1)
    );

    half_adder_sync #(.WIDTH(3), .SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_a(a3), .in_b(b3),
        .s_out(s3), .c_out(c3), .out_valid(v3)
    );

    // Advance to 1 time unit after the next rising edge: outputs settled, safe to drive.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic [0:0] s, input logic [0:0] c,
                          input logic v);
        check({tag, " s"}, {7'd0, s1}, {7'd0, s});
        check({tag, " c"}, {7'd0, c1}, {7'd0, c});
        check({tag, " v"}, {7'd0, v1}, {7'd0, v});
    endtask

    initial begin
        logic [1:0] tt_in [4];
        logic [1:0] tt_sc [4];
        tt_in = '{2'b00, 2'b10, 2'b01, 2'b11};   // {a,b}
        tt_sc = '{2'b00, 2'b10, 2'b10, 2'b01};   // {s,c}

        rst_n = 1'b0; a1 = 1'b1; b1 = 1'b1; a3 = 3'b000; b3 = 3'b000;

        // Reset held 5 cycles with both operands high.
        for (int i = 0; i < 5; i++) begin
            tick();
            check1($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0);
        end

        rst_n = 1'b1;
        tick(); check1("rel1", 1'b0, 1'b0, 1'b0);
        tick(); check1("rel2", 1'b0, 1'b0, 1'b0);
        tick(); check1("rel3", 1'b0, 1'b1, 1'b1);

        // Truth table, each combination held 50 cycles.
        for (int t = 0; t < 4; t++) begin
            {a1, b1} = tt_in[t];
            for (int n = 1; n <= 50; n++) begin
                tick();
                if (n >= 3)
                    check1($sformatf("tt%0d_%0d", t, n), tt_sc[t][1], tt_sc[t][0], 1'b1);
            end
        end

        // Latency: a steps 0->1 just after edge k; dut3 steps at the same time.
        a1 = 1'b0; b1 = 1'b0;
        repeat (4) tick();
        check1("lat_pre", 1'b0, 1'b0, 1'b1);
        check("m_pre s", {5'd0, s3}, 8'h00);
        a1 = 1'b1; a3 = 3'b101; b3 = 3'b110;
        tick(); check1("lat1", 1'b0, 1'b0, 1'b1);
        tick(); check1("lat2", 1'b0, 1'b0, 1'b1);
        tick(); check1("lat3", 1'b1, 1'b0, 1'b1);
        check("m3 s", {5'd0, s3}, 8'h00);
        check("m3 c", {5'd0, c3}, 8'h00);
        tick();
        check("m4 s", {5'd0, s3}, 8'h03);
        check("m4 c", {5'd0, c3}, 8'h04);
        check("m4 v", {7'd0, v3}, 8'h01);

        // Pulse: one-cycle high on b with a=1.
        b1 = 1'b1;
        tick(); b1 = 1'b0;
        check1("pul1", 1'b1, 1'b0, 1'b1);
        tick(); check1("pul2", 1'b1, 1'b0, 1'b1);
        tick(); check1("pul3", 1'b0, 1'b1, 1'b1);
        tick(); check1("pul4", 1'b1, 1'b0, 1'b1);
        tick(); check1("pul5", 1'b1, 1'b0, 1'b1);

        // Mid-operation reset with a=b=1 (c=1 steady).
        b1 = 1'b1;
        repeat (4) tick();
        check1("mid_pre", 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        check1("mid_rst", 1'b0, 1'b0, 1'b0);
        check("mid_rst s3", {5'd0, s3}, 8'h00);
        check("mid_rst v3", {7'd0, v3}, 8'h00);
        tick(); check1("mid1", 1'b0, 1'b0, 1'b0);
        tick(); check1("mid2", 1'b0, 1'b0, 1'b0);
        tick(); check1("mid3", 1'b0, 1'b1, 1'b1);
        check("mid3 v3", {7'd0, v3}, 8'h00);
        tick();
        check("mid4 v3", {7'd0, v3}, 8'h01);
        check("mid4 s3", {5'd0, s3}, 8'h03);
        check("mid4 c3", {5'd0, c3}, 8'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
